// File: rtl/color_detector.sv
// color_detector: classifies RGB332 samples as red/blue, counts per frame and publishes a verdict; window test enabled by COLOR_DET_ROI_EN
module color_detector #(
   parameter int WIDTH       = 176,
   parameter int HEIGHT      = 144,
   parameter int RED_THRESH  = 2000,
   parameter int BLUE_THRESH = 2000,
   parameter int ROI_X0      = 44,
   parameter int ROI_X1      = 131,
   parameter int ROI_Y0      = 36,
   parameter int ROI_Y1      = 107
) (
   input  logic        CLK,
   input  logic        RES,
   input  logic [7:0]  PIXEL,
   input  logic        SAMP_RDY,
   input  logic [14:0] X,
   input  logic [14:0] Y,
   input  logic        VSYNC,
   output logic [14:0] RED_CNT,
   output logic [14:0] BLUE_CNT,
   output logic [1:0]  RESULT,
   output logic        RESULT_VALID
);
`ifdef COLOR_DET_ROI_EN
   localparam logic ROI_ON = 1'b1;
`else
   localparam logic ROI_ON = 1'b0;
`endif
   localparam logic [14:0] W_L  = 15'(WIDTH);
   localparam logic [14:0] H_L  = 15'(HEIGHT);
   localparam logic [14:0] RT_L = 15'(RED_THRESH);
   localparam logic [14:0] BT_L = 15'(BLUE_THRESH);
   localparam logic [14:0] RX0  = 15'(ROI_X0);
   localparam logic [14:0] RX1  = 15'(ROI_X1);
   localparam logic [14:0] RY0  = 15'(ROI_Y0);
   localparam logic [14:0] RY1  = 15'(ROI_Y1);
   localparam logic [14:0] SAT  = 15'h7fff;

   typedef enum logic [1:0] {IDLE, ACCUM, EVAL} state_t;

   state_t      state, next;
   logic        rdy_q, vsync_q;
   logic        strobe, frame_edge;
   logic        is_red, is_blue, in_win;
   logic        clr, load, cnt_en;
   logic        r_ok, b_ok;
   logic [1:0]  verdict;
   logic [14:0] red_acc, blue_acc;

   assign strobe     = SAMP_RDY & ~rdy_q;
   assign frame_edge = VSYNC & ~vsync_q;
   assign is_red     = PIXEL[7:5] >= 3'd5 && PIXEL[4:2] <= 3'd2 && PIXEL[1:0] <= 2'd1;
   assign is_blue    = PIXEL[1:0] == 2'd3 && PIXEL[7:5] <= 3'd2 && PIXEL[4:2] <= 3'd3;
   assign in_win     = X < W_L && Y < H_L &&
                       (!ROI_ON || (X >= RX0 && X <= RX1 && Y >= RY0 && Y <= RY1));
   assign r_ok       = RED_CNT >= RT_L;
   assign b_ok       = BLUE_CNT >= BT_L;
   assign verdict    = (r_ok && b_ok) ? ((RED_CNT > BLUE_CNT) ? 2'b01 :
                                         (BLUE_CNT > RED_CNT) ? 2'b10 : 2'b11)
                                      : {b_ok, r_ok};

   // state register
   always_ff @(posedge CLK or negedge RES) begin
      if (!RES) state <= IDLE;
      else      state <= next;
   end

   // next state and datapath controls; a strobe coinciding with a frame edge is dropped
   always_comb begin
      next   = state;
      clr    = 1'b0;
      load   = 1'b0;
      cnt_en = 1'b0;
      case (state)
         IDLE: begin
            next = frame_edge ? ACCUM : IDLE;
            clr  = frame_edge;
         end
         ACCUM: begin
            next   = frame_edge ? EVAL : ACCUM;
            clr    = frame_edge;
            load   = frame_edge;
            cnt_en = !frame_edge && strobe && in_win;
         end
         EVAL: begin
            next   = ACCUM;
            cnt_en = strobe && in_win;
         end
         default: next = IDLE;
      endcase
   end

   // edge detectors, saturating accumulators, published counts and verdict
   always_ff @(posedge CLK or negedge RES) begin
      if (!RES) begin
         rdy_q        <= 1'b0;
         vsync_q      <= 1'b0;
         red_acc      <= '0;
         blue_acc     <= '0;
         RED_CNT      <= '0;
         BLUE_CNT     <= '0;
         RESULT       <= 2'b00;
         RESULT_VALID <= 1'b0;
      end else begin
         rdy_q        <= SAMP_RDY;
         vsync_q      <= VSYNC;
         red_acc      <= clr ? '0 : red_acc + 15'(cnt_en && is_red && red_acc != SAT);
         blue_acc     <= clr ? '0 : blue_acc + 15'(cnt_en && is_blue && blue_acc != SAT);
         RED_CNT      <= load ? red_acc : RED_CNT;
         BLUE_CNT     <= load ? blue_acc : BLUE_CNT;
         RESULT       <= (state == EVAL) ? verdict : RESULT;
         RESULT_VALID <= state == EVAL;
      end
   end
endmodule
